fifo_stream_out: RTL and testbench

Drain stage that sits directly downstream of `fifo`. It pops the fifo's first-word-fall-through head through `rdEn`/`empty` and presents the words on a registered valid/ready stream with a 2-entry output buffer. No combinational path from `out_ready` to the fifo's `rdEn`, so the consumer can be timing-isolated while still sustaining one word per cycle.

---
 rtl/fifo_stream_out_pkg.sv | 19 +
 rtl/fifo.sv | 52 +++++
 rtl/fifo_stream_out_skid_buffer2.sv | 75 +++++++
 rtl/fifo_stream_out.sv | 48 ++++
 tb/tb_fifo_stream_out.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_out_pkg.sv
`default_nettype none
// ============================================================================
// fifo_stream_out_pkg : shared constants and helpers for the fifo drain stage
// Revision : 1.0
// ============================================================================
package fifo_stream_out_pkg;

    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] CNT_EMPTY = 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
    localparam logic [CNT_W-1:0] CNT_FULL  = 2'd2;

    function automatic logic cnt_has_room(input logic [CNT_W-1:0] cnt);
        return (cnt < CNT_FULL);
    endfunction

endpackage : fifo_stream_out_pkg
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// fifo : first-word-fall-through synchronous fifo, 2**Q_DEPTH_BITS entries
// Revision : 1.0
// ============================================================================
module fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int Q_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  full,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  empty
);

    localparam int DEPTH = 1 << Q_DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [Q_DEPTH_BITS:0] wptr_q;
    logic [Q_DEPTH_BITS:0] rptr_q;
    logic                  w_do_write;
    logic                  w_do_read;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[Q_DEPTH_BITS] != rptr_q[Q_DEPTH_BITS]) &&
                   (wptr_q[Q_DEPTH_BITS-1:0] == rptr_q[Q_DEPTH_BITS-1:0]);

    assign w_do_write = wrEn && !full;
    assign w_do_read  = rdEn && !empty;
    assign read_data  = mem_q[rptr_q[Q_DEPTH_BITS-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_write) wptr_q <= wptr_q + 1'b1;
            if (w_do_read)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) mem_q[wptr_q[Q_DEPTH_BITS-1:0]] <= write_data;
    end

endmodule : fifo
`default_nettype wire

// File: rtl/fifo_stream_out_skid_buffer2.sv
`default_nettype none
// ============================================================================
// skid_buffer2 : two-entry registered valid/ready buffer with flush
// Revision : 1.0
// ============================================================================
module skid_buffer2
    import fifo_stream_out_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  w_push;
    logic                  w_take;

    // in_ready depends only on count, so the upstream pop never sees out_ready.
    assign in_ready_o  = cnt_has_room(count_q);
    assign out_valid_o = (count_q != CNT_EMPTY);
    assign out_data_o  = ent0_q;
    assign count_o     = count_q;

    assign w_push = in_valid_i && in_ready_o;
    assign w_take = out_valid_o && out_ready_i;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = CNT_EMPTY;
        end else begin
            case ({w_push, w_take})
                2'b10: begin
                    if (count_q == CNT_EMPTY) ent0_d = in_data_i;
                    else                      ent1_d = in_data_i;
                    count_d = count_q + CNT_ONE;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - CNT_ONE;
                end
                // Push implies count < 2 and take implies count > 0, so count is 1.
                2'b11: ent0_d = in_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= CNT_EMPTY;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

endmodule : skid_buffer2
`default_nettype wire

// File: rtl/fifo_stream_out.sv
`default_nettype none
// ============================================================================
// fifo_stream_out : drains a FWFT fifo onto a registered valid/ready stream
// Revision : 1.0
// ============================================================================
module fifo_stream_out
    import fifo_stream_out_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rdEn,
    output logic                  fifo_peek,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            occupancy
);

    logic w_head_avail;
    logic w_buf_ready;

    // Gating with reset keeps the pop strobe low while reset is asserted.
    assign w_head_avail = reset && !fifo_empty && !flush;
    assign fifo_rdEn    = w_head_avail && w_buf_ready;
    assign fifo_peek    = 1'b0;

    skid_buffer2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (w_head_avail),
        .in_data_i   (fifo_read_data),
        .in_ready_o  (w_buf_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .count_o     (occupancy)
    );

endmodule : fifo_stream_out
`default_nettype wire

// File: tb/tb_fifo_stream_out.sv
`default_nettype none
// ============================================================================
// tb_fifo_stream_out : directed bench, real fifo feeding fifo_stream_out
// Revision : 1.0
// ============================================================================
module tb_fifo_stream_out;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data;
    logic        fifo_rdEn;
    logic        fifo_peek;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo #(.DATA_WIDTH(32), .Q_DEPTH_BITS(3)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wrEn       (wr_en),
        .write_data (wr_data),
        .full       (fifo_full),
        .rdEn       (fifo_rdEn),
        .read_data  (fifo_rd_data),
        .empty      (fifo_empty)
    );

    fifo_stream_out #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_read_data (fifo_rd_data),
        .fifo_empty     (fifo_empty),
        .fifo_rdEn      (fifo_rdEn),
        .fifo_peek      (fifo_peek),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %0d want 0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_cmp++; if (fifo_rdEn !== 1'b0) begin n_err++; $display("FAIL rst_rden: got %0b want 0", fifo_rdEn); end
        n_cmp++; if (fifo_peek !== 1'b0) begin n_err++; $display("FAIL peek: got %0b want 0", fifo_peek); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_word(32'd100);
        n_cmp++; if (fifo_rdEn !== 1'b1) begin n_err++; $display("FAIL single_rden: got %0b want 1", fifo_rdEn); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_v0: got %0b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_v1: got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'd100) begin n_err++; $display("FAIL single_data: got %0d want 100", out_data); end
        n_cmp++; if (fifo_rdEn !== 1'b0) begin n_err++; $display("FAIL single_rden_off: got %0b want 0", fifo_rdEn); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_v2: got %0b want 0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL single_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4] = '{32'd51, 32'd78, 32'd39, 32'd23};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(exp[i]);
        tick();
        tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ: got %0d want 2", occupancy); end
        n_cmp++; if (out_data !== 32'd51) begin n_err++; $display("FAIL bp_data: got %0d want 51", out_data); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %0b want 1", out_valid); end
        n_cmp++; if (fifo_rdEn !== 1'b0) begin n_err++; $display("FAIL bp_rden: got %0b want 0", fifo_rdEn); end
        n_cmp++; if (fifo_rd_data !== 32'd39) begin n_err++; $display("FAIL bp_fifo_head: got %0d want 39", fifo_rd_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid[%0d]: got %0b want 1", i, out_valid); end
            n_cmp++; if (out_data !== exp[i]) begin n_err++; $display("FAIL rel_data[%0d]: got %0d want %0d", i, out_data, exp[i]); end
            if (i == 0) begin
                n_cmp++; if (fifo_rdEn !== 1'b0) begin n_err++; $display("FAIL rel_first_nopop: got %0b want 0", fifo_rdEn); end
            end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rel_done: got %0b want 0", out_valid); end
    endtask

    task automatic test_full_stream();
        logic [31:0] w [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        out_ready = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 8; i++) push_word(w[i] * 32'd11);
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL full_set: got %0b want 1", fifo_full); end
        flush = 1'b0;
        tick();
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL full_drop: got %0b want 0", fifo_full); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fs_valid[%0d]: got %0b want 1", i, out_valid); end
            n_cmp++; if (out_data !== w[i] * 32'd11) begin n_err++; $display("FAIL fs_data[%0d]: got %0d want %0d", i, out_data, w[i] * 32'd11); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fs_done: got %0b want 0", out_valid); end
    endtask

    task automatic test_toggle();
        logic [31:0] w [6] = '{32'd901, 32'd902, 32'd903, 32'd904, 32'd905, 32'd906};
        int idx = 0;
        out_ready = 1'b0;
        flush     = 1'b1;
        for (int i = 0; i < 6; i++) push_word(w[i]);
        flush = 1'b0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            out_ready = (c % 2 == 0);
            if (out_valid === 1'b1) begin
                n_cmp++; if (out_data !== w[idx]) begin n_err++; $display("FAIL tog_data[%0d]: got %0d want %0d", idx, out_data, w[idx]); end
                if (out_ready) idx++;
            end
            tick();
        end
        n_cmp++; if (idx !== 6) begin n_err++; $display("FAIL tog_count: got %0d want 6", idx); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL tog_done: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push_word(32'd11);
        push_word(32'd22);
        push_word(32'd44);
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL fl_occ_pre: got %0d want 2", occupancy); end
        flush = 1'b1;
        n_cmp++; if (fifo_rdEn !== 1'b0) begin n_err++; $display("FAIL fl_rden: got %0b want 0", fifo_rdEn); end
        tick();
        flush = 1'b0;
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL fl_occ: got %0d want 0", occupancy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %0b want 0", out_valid); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fl_after_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'd44) begin n_err++; $display("FAIL fl_after_data: got %0d want 44", out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_done: got %0b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push_word(32'd5);
        push_word(32'd6);
        tick();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL ar_occ_pre: got %0d want 2", occupancy); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL ar_data: got %0d want 0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL ar_occ: got %0d want 0", occupancy); end
        n_cmp++; if (fifo_rdEn !== 1'b0) begin n_err++; $display("FAIL ar_rden: got %0b want 0", fifo_rdEn); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_stream();
        test_toggle();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_stream_out
`default_nettype wire
